// File: rtl/trng_pkg.sv
// Shared constants and helpers for the TRNG conditioning path.
// Holds the generic CRC step used to compress raw entropy words.
package trng_pkg;

  localparam int CRC_MAX = 32;
  localparam int DAT_MAX = 256;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int DEF_SAMPLES_PER_OUT = 13;
  localparam int DEF_REP_LIMIT = 32;

  // Never returns 0, so counters stay at least 1 bit wide.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [CRC_MAX-1:0] crc_step(
    input logic [CRC_MAX-1:0] state,
    input logic [DAT_MAX-1:0] data,
    input int                 cw,
    input int                 dw,
    input logic [CRC_MAX-1:0] poly
  );
    logic [CRC_MAX-1:0] s;
    logic [CRC_MAX-1:0] mask;
    logic               fb;
    s = state;
    mask = (CRC_MAX'(1) << cw) - CRC_MAX'(1);
    for (int i = DAT_MAX - 1; i >= 0; i--) begin
      if (i < dw) begin
        fb = s[cw-1] ^ data[i];
        s = ({s[CRC_MAX-2:0], 1'b0} ^ (fb ? poly : '0)) & mask;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// First-word-fall-through FIFO for conditioned entropy words.
// Head reads as zero when empty; a push at full is accepted only with a pop.
module trng_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdat,
  output logic [WIDTH-1:0]           o_rdat,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    level_q;
  logic             pop;
  logic             wr;

  assign o_full  = level_q == LW'(DEPTH);
  assign o_empty = level_q == '0;
  assign o_level = level_q;
  assign o_rdat  = o_empty ? '0 : mem[rptr];

  assign pop = i_pop & ~o_empty;
  assign wr  = i_push & (~o_full | pop);

  always_ff @(posedge i_clk) begin
    if (wr) mem[wptr] <= i_wdat;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      unique case (1'b1)
        wr & ~pop: level_q <= level_q + 1'b1;
        pop & ~wr: level_q <= level_q - 1'b1;
        default:   level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/trng_conditioner.sv
// Multi-source entropy conditioner: CRC compression, warm-up discard,
// repetition-count health tests and an output FIFO.
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int                   NSRC            = 2,
  parameter int                   SRC_WIDTH       = 16,
  parameter int                   OUT_WIDTH       = 8,
  parameter logic [OUT_WIDTH-1:0] POLY            = CRC8_POLY,
  parameter int                   SAMPLES_PER_OUT = DEF_SAMPLES_PER_OUT,
  parameter int                   DEPTH           = 4,
  parameter int                   REP_LIMIT       = DEF_REP_LIMIT,
  parameter int                   WARMUP          = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_en,
  input  logic [NSRC*SRC_WIDTH-1:0]   i_sampled,
  input  logic                        i_raw_mode,
  input  logic                        i_clear_alarm,
  input  logic                        i_read,
  output logic [OUT_WIDTH-1:0]        o_dat,
  output logic                        o_valid,
  output logic [$clog2(DEPTH+1)-1:0]  o_level,
  output logic                        o_warm,
  output logic                        o_alarm,
  output logic                        o_overflow
);

  localparam int DW = NSRC * SRC_WIDTH;
  localparam int CW = clog2(SAMPLES_PER_OUT);
  localparam int WW = clog2(WARMUP + 1);
  localparam int RW = clog2(REP_LIMIT + 1);

  logic [OUT_WIDTH-1:0] crc_q;
  logic [OUT_WIDTH-1:0] crc_nxt;
  logic [OUT_WIDTH-1:0] push_dat;
  logic [CW-1:0]        cnt_q;
  logic [WW-1:0]        warm_q;
  logic [NSRC-1:0]      hit;
  logic                 raw_q;
  logic                 alarm_q;
  logic                 ovf_q;
  logic                 raw_chg;
  logic                 last;
  logic                 warm;
  logic                 done;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign crc_nxt = OUT_WIDTH'(crc_step(CRC_MAX'(crc_q),
                                       DAT_MAX'(i_sampled),
                                       OUT_WIDTH, DW,
                                       CRC_MAX'(POLY)));

  assign raw_chg  = i_raw_mode ^ raw_q;
  assign last     = cnt_q == CW'(SAMPLES_PER_OUT - 1);
  assign warm     = warm_q == WW'(WARMUP);
  assign done     = i_en & ~alarm_q & ~i_raw_mode & ~raw_chg & last;
  assign push     = ~alarm_q & i_en & (i_raw_mode | (done & warm));
  assign push_dat = i_raw_mode ? i_sampled[OUT_WIDTH-1:0] : crc_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_q   <= '0;
      cnt_q   <= '0;
      warm_q  <= '0;
      raw_q   <= 1'b0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      raw_q <= i_raw_mode;
      ovf_q <= push & fifo_full & ~(i_read & ~fifo_empty);
      if (alarm_q || raw_chg) begin
        crc_q <= '0;
        cnt_q <= '0;
      end else if (i_en && !i_raw_mode) begin
        if (last) begin
          crc_q <= '0;
          cnt_q <= '0;
        end else begin
          crc_q <= crc_nxt;
          cnt_q <= cnt_q + 1'b1;
        end
      end
      // Clear wins over a detection landing in the same cycle.
      if (i_clear_alarm) begin
        alarm_q <= 1'b0;
        warm_q  <= '0;
      end else begin
        if (|hit) alarm_q <= 1'b1;
        if (done && !warm) warm_q <= warm_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NSRC; k++) begin : g_hlth
    logic [SRC_WIDTH-1:0] smp;
    logic [SRC_WIDTH-1:0] prev_q;
    logic [RW-1:0]        run_q;
    logic [RW-1:0]        run_nxt;

    assign smp = i_sampled[k*SRC_WIDTH +: SRC_WIDTH];

    always_comb begin
      run_nxt = RW'(1);
      if (smp == prev_q)
        run_nxt = (run_q == RW'(REP_LIMIT)) ? run_q : run_q + 1'b1;
    end

    assign hit[k] = i_en & (run_nxt == RW'(REP_LIMIT));

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        prev_q <= '0;
        run_q  <= '0;
      end else begin
        if (i_en) prev_q <= smp;
        if (i_clear_alarm) run_q <= '0;
        else if (i_en)     run_q <= run_nxt;
      end
    end
  end

  trng_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (i_read),
    .i_wdat  (push_dat),
    .o_rdat  (o_dat),
    .o_level (o_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_valid    = ~fifo_empty;
  assign o_warm     = warm;
  assign o_alarm    = alarm_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner with default parameters.
// Expected CRC words come from a bit-serial reference of the polynomial.
module tb_trng_conditioner;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_en;
  logic [31:0] i_sampled;
  logic        i_raw_mode;
  logic        i_clear_alarm;
  logic        i_read;
  logic [7:0]  o_dat;
  logic        o_valid;
  logic [2:0]  o_level;
  logic        o_warm;
  logic        o_alarm;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;
  int n;

  trng_conditioner dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_en          (i_en),
    .i_sampled     (i_sampled),
    .i_raw_mode    (i_raw_mode),
    .i_clear_alarm (i_clear_alarm),
    .i_read        (i_read),
    .o_dat         (o_dat),
    .o_valid       (o_valid),
    .o_level       (o_level),
    .o_warm        (o_warm),
    .o_alarm       (o_alarm),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] smp(input int i);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'(i);
    hi = 16'(i + 32'h1000);
    return {hi, lo};
  endfunction

  function automatic logic [7:0] m_step(input logic [7:0] s,
                                        input logic [31:0] w);
    logic [7:0] r;
    logic       fb;
    r = s;
    for (int i = 31; i >= 0; i--) begin
      fb = r[7] ^ w[i];
      r = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] crc_range(input int a, input int b);
    logic [7:0] s;
    s = 8'h00;
    for (int i = a; i <= b; i++) s = m_step(s, smp(i));
    return s;
  endfunction

  // Post-warm-up word j (1-based) of a counting run.
  function automatic logic [7:0] word(input int j);
    return crc_range(14 + 13 * j, 26 + 13 * j);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic samp(input logic [31:0] w);
    i_en = 1'b1;
    i_sampled = w;
    tick();
    i_en = 1'b0;
  endtask

  task automatic sn();
    samp(smp(n));
    n++;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, o_dat, exp);
    i_read = 1'b1;
    tick();
    i_read = 1'b0;
  endtask

  task automatic warm_run(input string tag);
    logic early;
    early = 1'b0;
    n = 1;
    for (int i = 1; i <= 39; i++) begin
      sn();
      if (i == 25) chk({tag, "_warm25"}, o_warm, 0);
      if (i == 26) chk({tag, "_warm26"}, o_warm, 1);
      if (i < 39) early = early | o_valid;
    end
    chk({tag, "_early"}, early, 0);
    chk({tag, "_valid"}, o_valid, 1);
    chk({tag, "_dat"}, o_dat, crc_range(27, 39));
  endtask

  initial begin
    i_reset = 1'b1;
    i_en = 1'b0;
    i_sampled = '0;
    i_raw_mode = 1'b0;
    i_clear_alarm = 1'b0;
    i_read = 1'b0;
    tick();
    tick();
    chk("rst_dat", o_dat, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_level", o_level, 0);
    chk("rst_warm", o_warm, 0);
    chk("rst_alarm", o_alarm, 0);
    chk("rst_ovf", o_overflow, 0);
    i_reset = 1'b0;

    warm_run("s1");

    // Fill without reading: words 5 and 6 overflow.
    for (int i = 40; i <= 104; i++) begin
      sn();
      if (i == 78) chk("lvl_w4", o_level, 4);
      if (i == 90) chk("ovf_none", o_overflow, 0);
      if (i == 91) chk("ovf_w5", o_overflow, 1);
      if (i == 92) chk("ovf_w5_end", o_overflow, 0);
      if (i == 104) chk("ovf_w6", o_overflow, 1);
    end
    tick();
    chk("ovf_w6_end", o_overflow, 0);
    chk("lvl_full", o_level, 4);
    for (int j = 1; j <= 4; j++) pop_chk($sformatf("rd_w%0d", j), word(j));
    chk("drain_valid", o_valid, 0);
    chk("drain_dat", o_dat, 0);
    pop_chk("empty_read", 8'h00);
    chk("empty_lvl", o_level, 0);

    // Words 7..10 fill, word 11 completes while popping.
    for (int i = 105; i <= 168; i++) sn();
    chk("pp_lvl_pre", o_level, 4);
    i_read = 1'b1;
    sn();
    i_read = 1'b0;
    chk("pp_lvl", o_level, 4);
    chk("pp_ovf", o_overflow, 0);
    for (int j = 8; j <= 11; j++) pop_chk($sformatf("pp_w%0d", j), word(j));
    chk("pp_empty", o_valid, 0);

    // Partial word, then raw bypass, then back to conditioning.
    for (int i = 0; i < 5; i++) sn();
    i_raw_mode = 1'b1;
    samp(32'h1234_5678);
    chk("raw0_valid", o_valid, 1);
    chk("raw0_dat", o_dat, 8'h78);
    samp(32'h1234_5679);
    chk("raw1_lvl", o_level, 2);
    i_raw_mode = 1'b0;
    tick();
    pop_chk("raw_pop0", 8'h78);
    pop_chk("raw_pop1", 8'h79);
    for (int i = 0; i < 12; i++) sn();
    chk("fresh_early", o_valid, 0);
    sn();
    chk("fresh_valid", o_valid, 1);
    chk("fresh_dat", o_dat, crc_range(n - 13, n - 1));

    // Reset mid-accumulation with three words queued.
    for (int i = 0; i < 26; i++) sn();
    chk("q3_lvl", o_level, 3);
    for (int i = 0; i < 5; i++) sn();
    i_reset = 1'b1;
    tick();
    chk("mrst_valid", o_valid, 0);
    chk("mrst_lvl", o_level, 0);
    chk("mrst_warm", o_warm, 0);
    chk("mrst_dat", o_dat, 0);
    i_reset = 1'b0;
    warm_run("s6");

    // Stuck source 1 raises the alarm after 32 identical samples.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    for (int m = 1; m <= 45; m++) begin
      samp({16'hA5A5, 16'(m)});
      if (m == 31) chk("al_31", o_alarm, 0);
      if (m == 32) chk("al_32", o_alarm, 1);
    end
    chk("al_sticky", o_alarm, 1);
    chk("al_nopush", o_valid, 0);
    i_clear_alarm = 1'b1;
    tick();
    i_clear_alarm = 1'b0;
    chk("clr_alarm", o_alarm, 0);
    chk("clr_warm", o_warm, 0);
    warm_run("s2");
    chk("s2_alarm", o_alarm, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
